// File: rtl/clk_phase_gen.sv
// clk_phase_gen: multi-channel divided-clock / clock-enable generator.
// Each channel produces a square wave of period d+1 and a one-cycle enable at a
// programmable phase. Any accepted reconfiguration realigns every channel and
// runs a fixed-length relock window before the outputs are declared valid again.
module clk_phase_gen #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEF_DIV     = 1,
    parameter int DEF_PH      = 0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_ph,
    output logic [NCH-1:0]   clk_o,
    output logic [NCH-1:0]   ce_o,
    output logic             locked
);

    localparam int LCW = $clog2(LOCK_CYCLES);
    localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEF_D = (DEF_DIV == 0) ? CNT_W'(1) : CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_P = (CNT_W'(DEF_PH) > DEF_D) ? DEF_D : CNT_W'(DEF_PH);
    localparam logic [3:0]       NCH_L = 4'(NCH);

    typedef enum logic {
        LOCKING,
        RUN
    } state_t;

    // Counter start value so that the enable fires ph cycles after the first RUN
    // cycle: (P - ph) mod P, kept in CNT_W bits so d = 2^CNT_W-1 wraps natively.
    function automatic logic [CNT_W-1:0] loadValue(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] ph);
        return (ph == '0) ? '0 : (d - ph + CNT_W'(1));
    endfunction

    state_t         state_q;
    logic [LCW-1:0] lockCnt_q;
    logic           locked_q;
    logic           ready_q;
    logic [NCH-1:0] clk_q;
    logic [NCH-1:0] ce_q;

    logic [CNT_W-1:0] div_q [NCH];
    logic [CNT_W-1:0] ph_q  [NCH];
    logic [CNT_W-1:0] pc_q  [NCH];
    logic [CNT_W-1:0] div_d [NCH];
    logic [CNT_W-1:0] ph_d  [NCH];
    logic [CNT_W-1:0] pcLoad [NCH];
    logic [CNT_W-1:0] pcInc  [NCH];
    logic [NCH-1:0]   chClk;
    logic [NCH-1:0]   chCe;

    logic             chValid;
    logic             accept;
    logic             lockDone;
    logic             advance;
    logic [CNT_W-1:0] wrDiv;
    logic [CNT_W-1:0] wrPh;
    logic [CNT_W:0]   halfLen;

    // Handshake decode, clamped write values and per-channel next-state terms.
    always_comb begin
        chValid  = ({1'b0, cfg_ch} < NCH_L);
        accept   = cfg_valid && ready_q && chValid;
        lockDone = (state_q == LOCKING) && (lockCnt_q == LOCK_LAST);
        advance  = ((state_q == RUN) && !accept) || lockDone;
        wrDiv    = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        wrPh     = (cfg_ph > wrDiv) ? wrDiv : cfg_ph;
        halfLen  = '0;
        for (int i = 0; i < NCH; i++) begin
            div_d[i] = div_q[i];
            ph_d[i]  = ph_q[i];
            if (accept && (cfg_ch == 3'(i))) begin
                div_d[i] = wrDiv;
                ph_d[i]  = wrPh;
            end
            pcLoad[i] = loadValue(div_d[i], ph_d[i]);
            pcInc[i]  = (pc_q[i] == div_q[i]) ? '0 : (pc_q[i] + CNT_W'(1));
            halfLen   = ({1'b0, div_q[i]} + (CNT_W+1)'(2)) >> 1;
            chClk[i]  = ({1'b0, pc_q[i]} < halfLen);
            chCe[i]   = (pc_q[i] == '0);
        end
    end

    // Stored channel configuration and phase counters: counters free-run while
    // outputs are live and sit at their realigned start value otherwise.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= DEF_D;
                ph_q[i]  <= DEF_P;
                pc_q[i]  <= loadValue(DEF_D, DEF_P);
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= div_d[i];
                ph_q[i]  <= ph_d[i];
                pc_q[i]  <= advance ? pcInc[i] : pcLoad[i];
            end
        end
    end

    // Lock sequencer with registered lock/ready flags and channel outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOCKING;
            lockCnt_q <= '0;
            locked_q  <= 1'b0;
            ready_q   <= 1'b0;
            clk_q     <= '0;
            ce_q      <= '0;
        end else begin
            clk_q <= advance ? chClk : '0;
            ce_q  <= advance ? chCe  : '0;
            case (state_q)
                LOCKING: begin
                    if (lockDone) begin
                        state_q  <= RUN;
                        locked_q <= 1'b1;
                        ready_q  <= 1'b1;
                    end else begin
                        lockCnt_q <= lockCnt_q + LCW'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        state_q   <= LOCKING;
                        lockCnt_q <= '0;
                        locked_q  <= 1'b0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= LOCKING;
                    lockCnt_q <= '0;
                    locked_q  <= 1'b0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_q;
    assign locked    = locked_q;
    assign clk_o     = clk_q;
    assign ce_o      = ce_q;

endmodule
